// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet core register block: word-offset decode,
// CTRL/MDIO_CMD field positions, AXI response codes and FSM state types.
package eth_pkg;

  // Register word indices (AXI address bits [4:2])
  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_STATUS     = 3'd1;
  localparam logic [2:0] REG_MDIO_CMD   = 3'd2;
  localparam logic [2:0] REG_MDIO_RDATA = 3'd3;
  localparam logic [2:0] REG_RX_CNT     = 3'd4;
  localparam logic [2:0] REG_SCRATCH    = 3'd5;
  localparam logic [2:0] REG_VERSION    = 3'd6;
  localparam logic [2:0] REG_UNMAPPED   = 3'd7;

  localparam int CTRL_TX_TEST_EN_BIT = 0;
  localparam int CTRL_RX_EN_BIT      = 1;

  localparam int MDIO_RW_BIT    = 31;
  localparam int MDIO_PHY_LSB   = 21;
  localparam int MDIO_REG_LSB   = 16;
  localparam int MDIO_WDATA_LSB = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_GOT_AW,
    WR_GOT_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/eth_axil_regs.sv
// AXI4-Lite register file for the Ethernet core: CTRL, STATUS, MDIO command/read data,
// RX frame counter, scratch and version. Define ETH_AXIL_SLVERR_EN to return SLVERR.
module eth_axil_regs
  import eth_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  AXI_Clk,
  input  logic                  AXI_Rstn,
  input  logic                  AXI_awvalid,
  output logic                  AXI_awready,
  input  logic [ADDR_WIDTH-1:0] AXI_awaddr,
  input  logic                  AXI_wvalid,
  output logic                  AXI_wready,
  input  logic [31:0]           AXI_wdata,
  output logic                  AXI_bvalid,
  output logic [1:0]            AXI_bresp,
  input  logic                  AXI_bready,
  input  logic                  AXI_arvalid,
  output logic                  AXI_arready,
  input  logic [ADDR_WIDTH-1:0] AXI_araddr,
  output logic                  AXI_rvalid,
  output logic [31:0]           AXI_rdata,
  output logic [1:0]            AXI_rresp,
  input  logic                  AXI_rready,
  output logic                  Ctrl_Tx_Test_En,
  output logic                  Ctrl_Rx_En,
  output logic                  Mdio_Start,
  output logic                  Mdio_Rw,
  output logic [4:0]            Mdio_Phy_Addr,
  output logic [4:0]            Mdio_Reg_Addr,
  output logic [15:0]           Mdio_Wdata,
  input  logic                  Mdio_Busy,
  input  logic [15:0]           Mdio_Rdata,
  input  logic                  Mdio_Rdata_Valid,
  input  logic                  Rx_Frame_Done
);

  wr_state_e   wr_state_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [2:0]  waddr_q;
  logic [31:0] wdata_q;

  rd_state_e   rd_state_q;
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [1:0]  ctrl_q;
  logic        mdio_rw_q, mdio_start_q, fresh_q;
  logic [4:0]  mdio_phy_q, mdio_reg_q;
  logic [15:0] mdio_wdata_q, mdio_rdata_q;
  logic [31:0] rx_cnt_q, rx_cnt_d, scratch_q;

  logic        aw_hs, w_hs, ar_hs, wr_fire, mdio_cmd_ok;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wr_word, rd_word;
  logic [1:0]  bresp_d, rresp_d;

  // Address bits outside [4:2] alias onto the same eight registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AXI_awaddr[ADDR_WIDTH-1:5], AXI_awaddr[1:0],
                              AXI_araddr[ADDR_WIDTH-1:5], AXI_araddr[1:0]};

  assign aw_hs  = AXI_awvalid && awready_q;
  assign w_hs   = AXI_wvalid && wready_q;
  assign ar_hs  = AXI_arvalid && arready_q;
  assign rd_idx = AXI_araddr[4:2];

  always_comb begin
    // NOTE: defaults first so no branch of the case leaves a signal unassigned (no latch).
    wr_fire = 1'b0;
    wr_idx  = AXI_awaddr[4:2];
    wr_word = AXI_wdata;
    case (wr_state_q)
      WR_IDLE:   wr_fire = aw_hs && w_hs;
      WR_GOT_AW: begin
        wr_fire = w_hs;
        wr_idx  = waddr_q;
      end
      WR_GOT_W:  begin
        wr_fire = aw_hs;
        wr_word = wdata_q;
      end
      default:   wr_fire = 1'b0;
    endcase
  end

  assign mdio_cmd_ok = wr_fire && (wr_idx == REG_MDIO_CMD) && !Mdio_Busy;

`ifdef ETH_AXIL_SLVERR_EN
  assign bresp_d = ((wr_idx == REG_UNMAPPED) || ((wr_idx == REG_MDIO_CMD) && Mdio_Busy))
                 ? RESP_SLVERR : RESP_OKAY;
  assign rresp_d = (rd_idx == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
`else
  assign bresp_d = RESP_OKAY;
  assign rresp_d = RESP_OKAY;
`endif

  // A clear coincident with a frame pulse leaves the count at 1.
  assign rx_cnt_d = (wr_fire && (wr_idx == REG_RX_CNT)) ? {31'b0, Rx_Frame_Done}
                                                        : rx_cnt_q + {31'b0, Rx_Frame_Done};

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      REG_CTRL:       rd_word = {30'b0, ctrl_q};
      REG_STATUS:     rd_word = {30'b0, Mdio_Busy, fresh_q};
      REG_MDIO_CMD:   rd_word = {mdio_rw_q, 5'b0, mdio_phy_q, mdio_reg_q, mdio_wdata_q};
      REG_MDIO_RDATA: rd_word = {16'b0, mdio_rdata_q};
      REG_RX_CNT:     rd_word = rx_cnt_q;
      REG_SCRATCH:    rd_word = scratch_q;
      REG_VERSION:    rd_word = VERSION;
      default:        rd_word = '0;
    endcase
  end

  // Readies are registered so they stay low throughout reset and rise one edge after release.
  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      // NOTE: sequential state uses non-blocking assignment so every block sees pre-edge values.
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_fire) begin
            wr_state_q <= WR_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= bresp_d;
          end else if (aw_hs) begin
            wr_state_q <= WR_GOT_AW;
            waddr_q    <= AXI_awaddr[4:2];
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
          end else if (w_hs) begin
            wr_state_q <= WR_GOT_W;
            wdata_q    <= AXI_wdata;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        WR_GOT_AW, WR_GOT_W: begin
          if (wr_fire) begin
            wr_state_q <= WR_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= bresp_d;
          end
        end
        default: begin
          if (AXI_bready) begin
            wr_state_q <= WR_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= RD_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_word;
            rresp_q    <= rresp_d;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        default: begin
          if (AXI_rready) begin
            rd_state_q <= RD_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      ctrl_q       <= '0;
      scratch_q    <= '0;
      mdio_rw_q    <= 1'b0;
      mdio_phy_q   <= '0;
      mdio_reg_q   <= '0;
      mdio_wdata_q <= '0;
      mdio_start_q <= 1'b0;
      mdio_rdata_q <= '0;
      fresh_q      <= 1'b0;
      rx_cnt_q     <= '0;
    end else begin
      mdio_start_q <= 1'b0;
      if (wr_fire && (wr_idx == REG_CTRL))    ctrl_q    <= wr_word[1:0];
      if (wr_fire && (wr_idx == REG_SCRATCH)) scratch_q <= wr_word;
      if (mdio_cmd_ok) begin
        mdio_rw_q    <= wr_word[MDIO_RW_BIT];
        mdio_phy_q   <= wr_word[MDIO_PHY_LSB +: 5];
        mdio_reg_q   <= wr_word[MDIO_REG_LSB +: 5];
        mdio_wdata_q <= wr_word[MDIO_WDATA_LSB +: 16];
        mdio_start_q <= 1'b1;
      end
      if (Mdio_Rdata_Valid) begin
        mdio_rdata_q <= Mdio_Rdata;
        fresh_q      <= 1'b1;
      end else if (ar_hs && (rd_idx == REG_MDIO_RDATA)) begin
        fresh_q      <= 1'b0;
      end
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign AXI_awready     = awready_q;
  assign AXI_wready      = wready_q;
  assign AXI_bvalid      = bvalid_q;
  assign AXI_bresp       = bresp_q;
  assign AXI_arready     = arready_q;
  assign AXI_rvalid      = rvalid_q;
  assign AXI_rdata       = rdata_q;
  assign AXI_rresp       = rresp_q;
  assign Ctrl_Tx_Test_En = ctrl_q[CTRL_TX_TEST_EN_BIT];
  assign Ctrl_Rx_En      = ctrl_q[CTRL_RX_EN_BIT];
  assign Mdio_Start      = mdio_start_q;
  assign Mdio_Rw         = mdio_rw_q;
  assign Mdio_Phy_Addr   = mdio_phy_q;
  assign Mdio_Reg_Addr   = mdio_reg_q;
  assign Mdio_Wdata      = mdio_wdata_q;

endmodule
